// File: rtl/code_entry_if.sv
// Operator panel to code_entry bundle: digit-select switches and raw buttons in, committed code and display status out.
// The master side is the operator panel/display; the slave side is the code_entry block.
interface code_entry_if;
  logic [2:0]      sw;
  logic            btn_edit;
  logic            btn_inc;
  logic            btn_dec;
  logic            btn_clr;
  logic [5:0][3:0] reg_cnt_cod;
  logic            sw_led_ena;
  logic            editing;
  logic            code_valid;

  modport master (
    output sw, btn_edit, btn_inc, btn_dec, btn_clr,
    input  reg_cnt_cod, sw_led_ena, editing, code_valid
  );

  modport slave (
    input  sw, btn_edit, btn_inc, btn_dec, btn_clr,
    output reg_cnt_cod, sw_led_ena, editing, code_valid
  );
endinterface

// File: rtl/code_entry.sv
// Debounced six-digit code editor with atomic commit; a press acts DB_CYCLES+4 cycles after the raw edge, no backpressure.
// Digits are BCD by default; define CODE_ENTRY_HEX_EN for full hex digits.
module code_entry #(
  parameter int unsigned DB_CYCLES = 500000
) (
  input logic         clk,
  input logic         rst,
  code_entry_if.slave bus
);
  localparam int unsigned CNT_W = $clog2(DB_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_EDIT, S_COMMIT} state_e;

  // Button bit order: {clr, dec, inc, edit}
  logic [3:0]            raw;
  logic [3:0]            sync1_q, sync2_q, acc_q, acc_dly_q, press_q;
  logic [3:0][CNT_W-1:0] cnt_q;

  assign raw = {bus.btn_clr, bus.btn_dec, bus.btn_inc, bus.btn_edit};

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      acc_q     <= '0;
      acc_dly_q <= '0;
      press_q   <= '0;
      cnt_q     <= '0;
    end else begin
      sync1_q   <= raw;
      sync2_q   <= sync1_q;
      acc_dly_q <= acc_q;
      press_q   <= acc_q & ~acc_dly_q;
      for (int i = 0; i < 4; i++) begin
        if (sync2_q[i] == acc_q[i]) begin
          cnt_q[i] <= '0;
        end else if (cnt_q[i] == CNT_MAX) begin
          acc_q[i] <= sync2_q[i];
          cnt_q[i] <= '0;
        end else begin
          cnt_q[i] <= cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  function automatic logic [3:0] dig_inc(input logic [3:0] d);
`ifdef CODE_ENTRY_HEX_EN
    return d + 4'd1;
`else
    return (d >= 4'd9) ? 4'd0 : d + 4'd1;
`endif
  endfunction

  function automatic logic [3:0] dig_dec(input logic [3:0] d);
`ifdef CODE_ENTRY_HEX_EN
    return d - 4'd1;
`else
    return (d == 4'd0 || d > 4'd9) ? 4'd9 : d - 4'd1;
`endif
  endfunction

  state_e          state_q, state_d;
  logic [5:0][3:0] shadow_q, shadow_d, code_q, code_d;
  logic            loaded_q, loaded_d;
  logic            p_edit, p_inc, p_dec, p_clr;
  logic            dig_sel;
  logic [2:0]      dig_idx;

  assign {p_clr, p_dec, p_inc, p_edit} = press_q;
  assign dig_sel = (bus.sw >= 3'd1) && (bus.sw <= 3'd6);
  assign dig_idx = bus.sw - 3'd1;

  always_comb begin
    state_d  = state_q;
    shadow_d = shadow_q;
    code_d   = code_q;
    loaded_d = loaded_q;
    case (state_q)
      S_IDLE: begin
        if (p_edit) begin
          state_d  = S_EDIT;
          shadow_d = code_q;
        end
      end
      S_EDIT: begin
        // edit wins outright; simultaneous inc and dec cancel
        if (p_edit) begin
          state_d = S_COMMIT;
        end else if (p_clr) begin
          shadow_d = '0;
        end else if (dig_sel && (p_inc != p_dec)) begin
          if (p_inc) shadow_d[dig_idx] = dig_inc(shadow_q[dig_idx]);
          else       shadow_d[dig_idx] = dig_dec(shadow_q[dig_idx]);
        end
      end
      S_COMMIT: begin
        code_d   = shadow_q;
        loaded_d = 1'b1;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      shadow_q <= '0;
      code_q   <= '0;
      loaded_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      shadow_q <= shadow_d;
      code_q   <= code_d;
      loaded_q <= loaded_d;
    end
  end

  assign bus.reg_cnt_cod = code_q;
  assign bus.sw_led_ena  = loaded_q && (state_q == S_IDLE);
  assign bus.editing     = (state_q == S_EDIT);
  assign bus.code_valid  = (state_q == S_COMMIT);
endmodule

// File: tb/tb_code_entry.sv
// Directed bench for code_entry with DB_CYCLES=4: reset, debounce timing, a table of edit sessions, and reset mid-edit.
module tb_code_entry;
  localparam int DB = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  code_entry_if bus();
  code_entry #(.DB_CYCLES(DB)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_vec = 0;
  int n_err = 0;
  int cv_cnt = 0;

  always @(negedge clk) if (!rst && bus.code_valid) cv_cnt++;

  typedef struct {
    logic [2:0]  sw;
    logic [3:0]  btn;   // {clr, dec, inc, edit}
    logic [23:0] exp;
  } vec_t;
  vec_t vt[13];

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic set_btn(input logic [3:0] m);
    bus.btn_edit = m[0];
    bus.btn_inc  = m[1];
    bus.btn_dec  = m[2];
    bus.btn_clr  = m[3];
  endtask

  task automatic press(input logic [3:0] m);
    set_btn(m);
    tick(6);
    set_btn(4'b0000);
    tick(14);
  endtask

  // Press edit from EDIT and check the commit timing and result.
  task automatic commit(input logic [23:0] exp, input string nm);
    int t;
    int c0;
    t  = 0;
    c0 = cv_cnt;
    set_btn(4'b0001);
    for (int i = 1; i <= 40; i++) begin
      tick(1);
      if (i == 6) set_btn(4'b0000);
      if (bus.code_valid) begin
        t = i;
        break;
      end
    end
    set_btn(4'b0000);
    chk({nm, "_lat"}, t, 8);
    tick(1);
    chk({nm, "_cv_pulse"}, bus.code_valid, 0);
    chk({nm, "_led"}, bus.sw_led_ena, 1);
    chk({nm, "_editing"}, bus.editing, 0);
    chk({nm, "_code"}, bus.reg_cnt_cod, exp);
    chk({nm, "_cv_count"}, cv_cnt - c0, 1);
    tick(12);
  endtask

  initial begin
    vt[0]  = '{3'd1, 4'b0010, 24'h900301};
    vt[1]  = '{3'd1, 4'b0100, 24'h900300};
`ifdef CODE_ENTRY_HEX_EN
    vt[2]  = '{3'd1, 4'b0100, 24'h90030F};
`else
    vt[2]  = '{3'd1, 4'b0100, 24'h900309};
`endif
    vt[3]  = '{3'd1, 4'b0010, 24'h900300};
`ifdef CODE_ENTRY_HEX_EN
    vt[4]  = '{3'd6, 4'b0010, 24'hA00300};
`else
    vt[4]  = '{3'd6, 4'b0010, 24'h000300};
`endif
    vt[5]  = '{3'd6, 4'b0100, 24'h900300};
    vt[6]  = '{3'd0, 4'b0010, 24'h900300};
    vt[7]  = '{3'd7, 4'b0010, 24'h900300};
    vt[8]  = '{3'd4, 4'b0110, 24'h900300};
    vt[9]  = '{3'd4, 4'b0010, 24'h901300};
    vt[10] = '{3'd3, 4'b1000, 24'h000000};
    vt[11] = '{3'd5, 4'b0010, 24'h010000};
    vt[12] = '{3'd5, 4'b1010, 24'h000000};

    rst    = 1'b1;
    bus.sw = 3'd0;
    set_btn(4'b0000);
    tick(3);
    chk("rst_code", bus.reg_cnt_cod, 0);
    chk("rst_led", bus.sw_led_ena, 0);
    chk("rst_editing", bus.editing, 0);
    chk("rst_cv", bus.code_valid, 0);
    rst = 1'b0;
    tick(20);
    chk("idle_cv_count", cv_cnt, 0);
    chk("idle_code", bus.reg_cnt_cod, 0);
    chk("idle_led", bus.sw_led_ena, 0);

    set_btn(4'b0001);
    tick(2);
    set_btn(4'b0000);
    tick(20);
    chk("glitch_editing", bus.editing, 0);

    set_btn(4'b0001);
    tick(7);
    chk("lat_cycle7", bus.editing, 0);
    tick(1);
    chk("lat_cycle8", bus.editing, 1);
    tick(2);
    set_btn(4'b0000);
    tick(14);
    commit(24'h000000, "first");

    press(4'b0001);
    chk("main_editing", bus.editing, 1);
    bus.sw = 3'd3;
    repeat (3) press(4'b0010);
    bus.sw = 3'd6;
    press(4'b0100);
    commit(24'h900300, "main");

    for (int v = 0; v < 13; v++) begin
      press(4'b0001);
      bus.sw = vt[v].sw;
      press(vt[v].btn);
      commit(vt[v].exp, $sformatf("vec%0d", v));
    end

    press(4'b0001);
    for (int d = 1; d <= 6; d++) begin
      bus.sw = 3'(d);
      repeat (7 - d) press(4'b0010);
    end
    commit(24'h123456, "c123456");

    press(4'b0001);
    bus.sw = 3'd1;
    press(4'b0010);
    chk("pre_rst_editing", bus.editing, 1);
    rst = 1'b1;
    tick(2);
    chk("mid_rst_code", bus.reg_cnt_cod, 0);
    chk("mid_rst_led", bus.sw_led_ena, 0);
    chk("mid_rst_editing", bus.editing, 0);
    chk("mid_rst_cv", bus.code_valid, 0);
    rst = 1'b0;
    tick(4);
    press(4'b0001);
    chk("post_rst_editing", bus.editing, 1);
    commit(24'h000000, "post_rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
